// File: rtl/ram_access_ctrl_if.sv
// Request/response bundle between the coherence/arbitration controller and ram_access_ctrl.
// The master drives the single RAM request and the slave reports load data and progress.
interface ram_access_ctrl_if;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (
    output ramREN,
    output ramWEN,
    output ramaddr,
    output ramstore,
    input  ramload,
    input  ramstate
  );

  modport slave (
    input  ramREN,
    input  ramWEN,
    input  ramaddr,
    input  ramstore,
    output ramload,
    output ramstate
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Sequences one RAM request at a time onto a word-wide synchronous SRAM with LAT wait states.
// Optional RAM_STATS_EN adds saturating read/write/restart/error event counters.
module ram_access_ctrl #(
  parameter int LAT    = 2,
  parameter int MEM_AW = 14
) (
  input  logic              CLK,
  input  logic              RST,
  ram_access_ctrl_if.slave  ramif,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef RAM_STATS_EN
  ,
  output logic [31:0]       stat_rd,
  output logic [31:0]       stat_wr,
  output logic [31:0]       stat_rst,
  output logic [31:0]       stat_err
`endif
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam logic [3:0] LAT_C = 4'(LAT);

  ramstate_t         state, next_state;
  logic [3:0]        cnt, next_cnt;
  logic              latch_ren, latch_wen, next_ren, next_wen;
  logic [MEM_AW-1:0] latch_word, next_word;
  logic [31:0]       latch_data, next_data;
  logic [31:0]       load_q;

  logic              req_any, req_valid, req_differs, load_req;

  // A request is only usable as a single aligned operation inside the SRAM window;
  // once invalid requests are filtered out the latched word index fully identifies it.
  assign req_any     = ramif.ramREN | ramif.ramWEN;
  assign req_valid   = (ramif.ramREN ^ ramif.ramWEN)
                     && (ramif.ramaddr[1:0] == 2'b00)
                     && ((ramif.ramaddr >> (MEM_AW + 2)) == 32'd0);
  assign req_differs = (ramif.ramREN != latch_ren) || (ramif.ramWEN != latch_wen)
                     || (ramif.ramaddr[MEM_AW+1:2] != latch_word)
                     || (ramif.ramstore != latch_data);

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    load_req   = 1'b0;
    case (state)
      BUSY: begin
        if (!req_any) begin
          next_state = FREE;
          next_cnt   = 4'd0;
        end else if (!req_valid) begin
          next_state = ERROR;
          next_cnt   = 4'd0;
        end else if (req_differs) begin
          load_req = 1'b1;
        end else if (cnt == LAT_C) begin
          next_state = ACCESS;
        end else begin
          next_cnt = cnt + 4'd1;
        end
      end
      default: begin
        if (!req_any) begin
          next_state = FREE;
          next_cnt   = 4'd0;
        end else if (!req_valid) begin
          next_state = ERROR;
          next_cnt   = 4'd0;
        end else begin
          load_req = 1'b1;
        end
      end
    endcase

    next_ren  = latch_ren;
    next_wen  = latch_wen;
    next_word = latch_word;
    next_data = latch_data;
    if (load_req) begin
      next_state = BUSY;
      next_cnt   = 4'd1;
      next_ren   = ramif.ramREN;
      next_wen   = ramif.ramWEN;
      next_word  = ramif.ramaddr[MEM_AW+1:2];
      next_data  = ramif.ramstore;
    end
  end

  // Strobes are registered from the next state so the read lands in the last BUSY
  // cycle and the write occupies exactly the ACCESS cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= FREE;
      cnt        <= 4'd0;
      latch_ren  <= 1'b0;
      latch_wen  <= 1'b0;
      latch_word <= '0;
      latch_data <= 32'd0;
      load_q     <= 32'd0;
      mem_ren    <= 1'b0;
      mem_wen    <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      latch_ren  <= next_ren;
      latch_wen  <= next_wen;
      latch_word <= next_word;
      latch_data <= next_data;
      mem_ren    <= (next_state == BUSY) && (next_cnt == LAT_C) && next_ren;
      mem_wen    <= (next_state == ACCESS) && next_wen;
      if ((state == ACCESS) && latch_ren) begin
        load_q <= mem_rdata;
      end
    end
  end

  assign mem_addr       = latch_word;
  assign mem_wdata      = latch_data;
  assign ramif.ramstate = state;
  assign ramif.ramload  = ((state == ACCESS) && latch_ren) ? mem_rdata : load_q;

`ifdef RAM_STATS_EN
  logic ev_rd, ev_wr, ev_restart, ev_err;

  assign ev_rd      = (state == ACCESS) && latch_ren;
  assign ev_wr      = (state == ACCESS) && latch_wen;
  assign ev_restart = (state == BUSY) && req_any && req_valid && req_differs;
  assign ev_err     = (next_state == ERROR) && (state != ERROR);

  // Event counters stick at all-ones rather than wrapping back to zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_rd  <= 32'd0;
      stat_wr  <= 32'd0;
      stat_rst <= 32'd0;
      stat_err <= 32'd0;
    end else begin
      if (ev_rd && (stat_rd != 32'hFFFF_FFFF))       stat_rd  <= stat_rd + 32'd1;
      if (ev_wr && (stat_wr != 32'hFFFF_FFFF))       stat_wr  <= stat_wr + 32'd1;
      if (ev_restart && (stat_rst != 32'hFFFF_FFFF)) stat_rst <= stat_rst + 32'd1;
      if (ev_err && (stat_err != 32'hFFFF_FFFF))     stat_err <= stat_err + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl (LAT=2, MEM_AW=14) with a behavioural registered SRAM.
// Define RAM_STATS_EN to also exercise the event counters.
module tb_ram_access_ctrl;
  logic        CLK = 1'b0;
  logic        RST;
  logic [13:0] mem_addr;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef RAM_STATS_EN
  logic [31:0] stat_rd, stat_wr, stat_rst, stat_err;
`endif

  int compareCount = 0;
  int failCount    = 0;
  int wenPulses    = 0;
  int renPulses    = 0;
  int bothHigh     = 0;
  int wenBefore;
  int renBefore;

  logic [31:0] sram    [0:16383];
  bit          written [0:16383];

  ram_access_ctrl_if bus();

  ram_access_ctrl #(.LAT(2), .MEM_AW(14)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ramif     (bus),
    .mem_addr  (mem_addr),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef RAM_STATS_EN
    ,
    .stat_rd   (stat_rd),
    .stat_wr   (stat_wr),
    .stat_rst  (stat_rst),
    .stat_err  (stat_err)
`endif
  );

  always #5 CLK = ~CLK;

  // Power-up SRAM contents for words never written during the run.
  function automatic logic [31:0] initWord(input logic [13:0] a);
    case (a)
      14'd4:   initWord = 32'hDEAD_BEEF;
      14'd5:   initWord = 32'h5555_0005;
      14'd16:  initWord = 32'hA5A5_0016;
      default: initWord = {18'h0, a};
    endcase
  endfunction

  always @(posedge CLK) begin
    if (mem_wen) begin
      sram[mem_addr]    <= mem_wdata;
      written[mem_addr] <= 1'b1;
      wenPulses         <= wenPulses + 1;
    end
    if (mem_ren) begin
      mem_rdata <= written[mem_addr] ? sram[mem_addr] : initWord(mem_addr);
      renPulses <= renPulses + 1;
    end
    if (mem_ren && mem_wen) bothHigh <= bothHigh + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] data);
    bus.ramREN   = ren;
    bus.ramWEN   = wen;
    bus.ramaddr  = addr;
    bus.ramstore = data;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " ramstate"}, 32'(bus.ramstate), 32'd0);
    checkOutput({tag, " ramload"}, bus.ramload, 32'd0);
    checkOutput({tag, " mem_ren"}, 32'(mem_ren), 32'd0);
    checkOutput({tag, " mem_wen"}, 32'(mem_wen), 32'd0);
    checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, " mem_wdata"}, mem_wdata, 32'd0);
  endtask

  // One complete access with LAT=2: BUSY, BUSY, ACCESS, then the request is dropped.
  task automatic runAccess(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] expLoad, input string tag);
    logic [31:0] word;
    word = {18'h0, addr[15:2]};
    applyStimulus(ren, wen, addr, data);
    checkOutput({tag, " busy1 state"}, 32'(bus.ramstate), 32'd1);
    checkOutput({tag, " busy1 mem_ren"}, 32'(mem_ren), 32'd0);
    applyStimulus(ren, wen, addr, data);
    checkOutput({tag, " busy2 state"}, 32'(bus.ramstate), 32'd1);
    checkOutput({tag, " busy2 mem_ren"}, 32'(mem_ren), 32'(ren));
    checkOutput({tag, " busy2 mem_wen"}, 32'(mem_wen), 32'd0);
    if (ren) checkOutput({tag, " busy2 mem_addr"}, 32'(mem_addr), word);
    applyStimulus(ren, wen, addr, data);
    checkOutput({tag, " access state"}, 32'(bus.ramstate), 32'd2);
    checkOutput({tag, " access mem_wen"}, 32'(mem_wen), 32'(wen));
    checkOutput({tag, " access mem_ren"}, 32'(mem_ren), 32'd0);
    if (ren) begin
      checkOutput({tag, " access ramload"}, bus.ramload, expLoad);
    end else begin
      checkOutput({tag, " access mem_addr"}, 32'(mem_addr), word);
      checkOutput({tag, " access mem_wdata"}, mem_wdata, data);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput({tag, " free state"}, 32'(bus.ramstate), 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    bus.ramREN = 1'b0; bus.ramWEN = 1'b0; bus.ramaddr = 32'd0; bus.ramstore = 32'd0;
    repeat (2) @(negedge CLK);
    checkResetOutputs("reset");
    RST = 1'b0;

    // Plain read, then the held load value once back in FREE.
    runAccess(1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, "T1");
    checkOutput("T1 load_q", bus.ramload, 32'hDEAD_BEEF);

    runAccess(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'd0, "T2");
    runAccess(1'b1, 1'b0, 32'h0000_0020, 32'd0, 32'h1234_5678, "T2 readback");

    // Address change in the first BUSY cycle restarts the wait count.
    applyStimulus(1'b1, 1'b0, 32'h10, 32'd0);
    checkOutput("T3 busy1 state", 32'(bus.ramstate), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h14, 32'd0);
    checkOutput("T3 restart state", 32'(bus.ramstate), 32'd1);
    checkOutput("T3 restart mem_ren", 32'(mem_ren), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h14, 32'd0);
    checkOutput("T3 busy2 state", 32'(bus.ramstate), 32'd1);
    checkOutput("T3 busy2 mem_ren", 32'(mem_ren), 32'd1);
    checkOutput("T3 busy2 mem_addr", 32'(mem_addr), 32'd5);
    applyStimulus(1'b1, 1'b0, 32'h14, 32'd0);
    checkOutput("T3 access state", 32'(bus.ramstate), 32'd2);
    checkOutput("T3 access ramload", bus.ramload, 32'h5555_0005);
    // Request still held in ACCESS starts a fresh access.
    applyStimulus(1'b1, 1'b0, 32'h14, 32'd0);
    checkOutput("T3 back-to-back state", 32'(bus.ramstate), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("T3 abort state", 32'(bus.ramstate), 32'd0);

    // Write aborted from BUSY never reaches the SRAM.
    wenBefore = wenPulses;
    applyStimulus(1'b0, 1'b1, 32'h50, 32'hFFFF_0000);
    checkOutput("abort busy state", 32'(bus.ramstate), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("abort free state", 32'(bus.ramstate), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("abort wen count", 32'(wenPulses), 32'(wenBefore));

    // Invalid requests: both strobes, misaligned, out of range.
    wenBefore = wenPulses;
    renBefore = renPulses;
    applyStimulus(1'b1, 1'b1, 32'h10, 32'd0);
    checkOutput("T4 both state", 32'(bus.ramstate), 32'd3);
    applyStimulus(1'b1, 1'b1, 32'h10, 32'd0);
    checkOutput("T4 held state", 32'(bus.ramstate), 32'd3);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("T4 drop state", 32'(bus.ramstate), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h3, 32'd0);
    checkOutput("T4 misaligned state", 32'(bus.ramstate), 32'd3);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("T4 drop2 state", 32'(bus.ramstate), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0001_0000, 32'd0);
    checkOutput("T4 range state", 32'(bus.ramstate), 32'd3);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("T4 wen count", 32'(wenPulses), 32'(wenBefore));
    checkOutput("T4 ren count", 32'(renPulses), 32'(renBefore));

    // Reset in the second BUSY cycle of a write.
    wenBefore = wenPulses;
    applyStimulus(1'b0, 1'b1, 32'h40, 32'hBAD0_BAD0);
    applyStimulus(1'b0, 1'b1, 32'h40, 32'hBAD0_BAD0);
    checkOutput("T5 busy2 state", 32'(bus.ramstate), 32'd1);
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    checkResetOutputs("T5 reset");
    RST = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("T5 wen count", 32'(wenPulses), 32'(wenBefore));
    runAccess(1'b1, 1'b0, 32'h40, 32'd0, 32'hA5A5_0016, "T5 readback");

    // Mix giving three reads, two writes, one restart and one error since the reset.
    runAccess(1'b0, 1'b1, 32'h44, 32'hCAFE_0001, 32'd0, "T6 wr1");
    runAccess(1'b0, 1'b1, 32'h48, 32'hCAFE_0002, 32'd0, "T6 wr2");
    applyStimulus(1'b1, 1'b0, 32'h44, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h48, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h48, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h48, 32'd0);
    checkOutput("T6 restart access state", 32'(bus.ramstate), 32'd2);
    checkOutput("T6 restart ramload", bus.ramload, 32'hCAFE_0002);
    applyStimulus(1'b1, 1'b1, 32'h44, 32'd0);
    checkOutput("T6 error state", 32'(bus.ramstate), 32'd3);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    runAccess(1'b1, 1'b0, 32'h44, 32'd0, 32'hCAFE_0001, "T6 rd3");
`ifdef RAM_STATS_EN
    checkOutput("T6 stat_rd", stat_rd, 32'd3);
    checkOutput("T6 stat_wr", stat_wr, 32'd2);
    checkOutput("T6 stat_rst", stat_rst, 32'd1);
    checkOutput("T6 stat_err", stat_err, 32'd1);
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    RST = 1'b0;
    checkOutput("T6 clr stat_rd", stat_rd, 32'd0);
    checkOutput("T6 clr stat_wr", stat_wr, 32'd0);
    checkOutput("T6 clr stat_rst", stat_rst, 32'd0);
    checkOutput("T6 clr stat_err", stat_err, 32'd0);
`endif

    checkOutput("strobe exclusivity", 32'(bothHigh), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end
endmodule
